fir_tdm_mux: RTL and testbench

Parametrised time-division sequencer/collector between an N-channel parallel audio source (I2S receiver) and one shared multi-channel streaming FIR with sop/eop framing. It serialises each input frame into per-channel FIR sink words and reassembles FIR source words into an aligned N-channel output frame for the I2S transmitter. Over the fixed 2-channel version it adds:
- generic channel count and sample widths;
- a one-frame input holding buffer with overrun detection;
- a FIR bypass mode;
- sop/eop framing-error detection.

---
 rtl/fir_tdm_pkg.sv | 32 +++
 rtl/fir_tdm_collect.sv | 129 ++++++++++++
 rtl/fir_tdm_mux.sv | 202 ++++++++++++++++++++
 tb/tb_fir_tdm_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_tdm_pkg.sv
// ---------------------------------------------------------------------------
// fir_tdm_pkg
// Shared definitions for the FIR time-division sequencer/collector:
//   - seq_state_t  : sink sequencer state encoding (IDLE / SEND / GAP)
//   - idx_w()      : index width for an NCH-channel frame, clog2(NCH), min 1
//   - align_sample : sign-extends an IN_W sample and left-aligns it in OUT_W
// ---------------------------------------------------------------------------
package fir_tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    // Channel index width; a single-bit index is kept for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Sign-extend the low in_w bits of s, then shift left by (out_w - in_w)
    // so the sample's MSB lands on bit out_w-1. Caller truncates to out_w.
    function automatic logic [63:0] align_sample(input logic [63:0] s,
                                                 input int          in_w,
                                                 input int          out_w);
        logic signed [63:0] v;
        v = $signed(s << (64 - in_w));
        v = v >>> (64 - in_w);
        return v <<< (out_w - in_w);
    endfunction

endpackage

// File: rtl/fir_tdm_collect.sv
// ---------------------------------------------------------------------------
// fir_tdm_collect
// Reassembles per-channel FIR source words into one packed NCH-channel frame
// and owns the output frame register (also loaded by the bypass path).
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_bypass              1 = FIR source words are discarded
//   i_clr                 clears the sticky frame-error flag
//   i_src_data/valid/sop/eop  FIR source word and framing
//   i_byp_load, i_byp_data    bypass frame to publish directly
//   o_data, o_valid       output frame and its one-cycle strobe
//   o_frame_err           sticky malformed-source-frame flag
// ---------------------------------------------------------------------------
module fir_tdm_collect
    import fir_tdm_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int OUT_W = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bypass,
    input  logic                 i_clr,
    input  logic [OUT_W-1:0]     i_src_data,
    input  logic                 i_src_valid,
    input  logic                 i_src_sop,
    input  logic                 i_src_eop,
    input  logic                 i_byp_load,
    input  logic [NCH*OUT_W-1:0] i_byp_data,
    output logic [NCH*OUT_W-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err
);

    // One extra bit so an index past NCH-1 is representable and detectable.
    localparam int CW = idx_w(NCH) + 1;

    logic [CW-1:0]        r_idx;
    logic                 r_in_frame;
    logic [NCH*OUT_W-1:0] r_asm;
    logic [NCH*OUT_W-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_frame_err;

    logic                 w_word;
    logic [CW-1:0]        w_slot;
    logic                 w_err;
    logic                 w_commit;
    logic                 w_wr;
    logic [NCH*OUT_W-1:0] w_asm_next;

    // Classify the incoming source word: error, commit, or plain store.
    always_comb begin
        w_word   = i_src_valid & ~i_bypass;
        w_slot   = i_src_sop ? '0 : r_idx;
        w_err    = 1'b0;
        w_commit = 1'b0;
        if (w_word) begin
            if (!i_src_sop && !r_in_frame) begin
                w_err = 1'b1;                       // no sop opened this frame
            end else if (w_slot > CW'(NCH - 1)) begin
                w_err = 1'b1;                       // more than NCH words
            end else if (i_src_eop) begin
                if (w_slot == CW'(NCH - 1)) begin
                    w_commit = 1'b1;
                end else begin
                    w_err = 1'b1;                   // eop too early
                end
            end else begin
                w_err = 1'b0;
            end
        end else begin
            w_err = 1'b0;
        end
        w_wr       = w_word & ~w_err;
        w_asm_next = r_asm;
        if (w_wr) begin
            w_asm_next[w_slot*OUT_W +: OUT_W] = i_src_data;
        end else begin
            w_asm_next = r_asm;
        end
    end

    // Assembly buffer, index counter, output frame register and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= '0;
            r_in_frame  <= 1'b0;
            r_asm       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_wr) begin
                r_asm <= w_asm_next;
            end
            if (w_word) begin
                if (w_err || w_commit) begin
                    // Frame closed either way; only a new sop reopens it.
                    r_in_frame <= 1'b0;
                    r_idx      <= '0;
                end else begin
                    r_in_frame <= 1'b1;
                    r_idx      <= w_slot + CW'(1);
                end
            end
            // Bypass and FIR commits are mutually exclusive in practice;
            // bypass takes precedence because FIR words are dropped then.
            if (i_byp_load) begin
                r_out_data  <= i_byp_data;
                r_out_valid <= 1'b1;
            end else if (w_commit) begin
                r_out_data  <= w_asm_next;
                r_out_valid <= 1'b1;
            end
            if (w_err) begin
                r_frame_err <= 1'b1;
            end else if (i_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_data      = r_out_data;
    assign o_valid     = r_out_valid;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/fir_tdm_mux.sv
// ---------------------------------------------------------------------------
// fir_tdm_mux
// Time-division sequencer/collector between an NCH-channel parallel audio
// source and one shared multi-channel streaming FIR. Input frames are
// serialised channel 0 first into sop/eop-framed sink bursts; FIR source
// words are reassembled into a packed output frame. Optional FIR bypass.
// Ports:
//   AMCLK_i, nARST        clock, asynchronous active-low reset
//   in_data_i, in_valid_i packed input frame and one-cycle strobe
//   bypass_i              1 = route input straight to output
//   clr_i                 clears overrun_o and frame_err_o
//   sink_*_o              FIR sink word and framing
//   source_*_i            FIR source word and framing
//   out_data_o, out_valid_o  packed output frame and one-cycle strobe
//   overrun_o, frame_err_o   sticky error flags
// ---------------------------------------------------------------------------
module fir_tdm_mux
    import fir_tdm_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int GAP   = 1
) (
    input  logic                 AMCLK_i,
    input  logic                 nARST,
    input  logic [NCH*IN_W-1:0]  in_data_i,
    input  logic                 in_valid_i,
    input  logic                 bypass_i,
    input  logic                 clr_i,
    output logic [IN_W-1:0]      sink_data_o,
    output logic                 sink_valid_o,
    output logic                 sink_sop_o,
    output logic                 sink_eop_o,
    input  logic [OUT_W-1:0]     source_data_i,
    input  logic                 source_valid_i,
    input  logic                 source_sop_i,
    input  logic                 source_eop_i,
    output logic [NCH*OUT_W-1:0] out_data_o,
    output logic                 out_valid_o,
    output logic                 overrun_o,
    output logic                 frame_err_o
);

    localparam int IDX_W    = idx_w(NCH);
    localparam int GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    seq_state_t           r_state;
    logic [IDX_W-1:0]     r_ch;
    logic [GAP_CW-1:0]    r_gap_cnt;
    logic [NCH*IN_W-1:0]  r_active;
    logic [NCH*IN_W-1:0]  r_pend;
    logic                 r_pend_full;
    logic [IN_W-1:0]      r_sink_data;
    logic                 r_sink_valid;
    logic                 r_sink_sop;
    logic                 r_sink_eop;
    logic                 r_overrun;

    logic                 w_decide;
    logic                 w_take;
    logic                 w_byp_load;
    logic                 w_ovr_set;
    logic [NCH*IN_W-1:0]  w_take_data;
    logic [IDX_W-1:0]     w_next_ch;
    logic [NCH*OUT_W-1:0] w_byp_data;

    // Decision point: the sequencer may accept a new frame into active now.
    // Pending always has priority over a fresh strobe to preserve order.
    always_comb begin
        w_decide = 1'b0;
        case (r_state)
            ST_IDLE: w_decide = 1'b1;
            ST_SEND: w_decide = (GAP == 0) && (r_ch == IDX_W'(NCH - 1));
            ST_GAP:  w_decide = (r_gap_cnt == GAP_CW'(GAP_LAST));
            default: w_decide = 1'b1;
        endcase
        w_take      = w_decide & (r_pend_full | in_valid_i);
        w_take_data = r_pend_full ? r_pend : in_data_i;
        w_byp_load  = w_take & bypass_i;
        w_ovr_set   = ~w_decide & in_valid_i & r_pend_full;
        w_next_ch   = r_ch + IDX_W'(1);
    end

    // Bypass path: each channel sign-extended and MSB-aligned into OUT_W.
    for (genvar k = 0; k < NCH; k++) begin : g_align
        assign w_byp_data[k*OUT_W +: OUT_W] =
            OUT_W'(align_sample(64'(w_take_data[k*IN_W +: IN_W]), IN_W, OUT_W));
    end

    // Pending buffer: one frame that arrived while the sequencer was busy.
    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_decide) begin
            if (r_pend_full && in_valid_i) begin
                r_pend <= in_data_i;            // pending drains and refills
            end else if (r_pend_full) begin
                r_pend_full <= 1'b0;
            end
        end else if (in_valid_i && !r_pend_full) begin
            r_pend      <= in_data_i;
            r_pend_full <= 1'b1;
        end
    end

    // Sticky overrun flag; a drop in the same cycle beats clr_i.
    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    // Sink sequencer FSM with registered sink framing outputs.
    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_gap_cnt    <= '0;
            r_active     <= '0;
            r_sink_data  <= '0;
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
        end else begin
            r_sink_sop <= 1'b0;
            if (w_take && !bypass_i) begin
                r_state      <= ST_SEND;
                r_active     <= w_take_data;
                r_ch         <= '0;
                r_sink_data  <= w_take_data[IN_W-1:0];
                r_sink_valid <= 1'b1;
                r_sink_sop   <= 1'b1;
                r_sink_eop   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sink_valid <= 1'b0;
                        r_sink_eop   <= 1'b0;
                    end
                    ST_SEND: begin
                        if (r_ch == IDX_W'(NCH - 1)) begin
                            r_sink_valid <= 1'b0;
                            r_sink_eop   <= 1'b0;
                            r_sink_data  <= '0;
                            r_gap_cnt    <= '0;
                            r_state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            r_ch         <= w_next_ch;
                            r_sink_data  <= r_active[w_next_ch*IN_W +: IN_W];
                            r_sink_eop   <= (w_next_ch == IDX_W'(NCH - 1));
                        end
                    end
                    ST_GAP: begin
                        if (w_decide) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GAP_CW'(1);
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_sink_valid <= 1'b0;
                        r_sink_eop   <= 1'b0;
                    end
                endcase
            end
        end
    end

    fir_tdm_collect #(
        .NCH   (NCH),
        .OUT_W (OUT_W)
    ) u_collect (
        .i_clk       (AMCLK_i),
        .i_rst_n     (nARST),
        .i_bypass    (bypass_i),
        .i_clr       (clr_i),
        .i_src_data  (source_data_i),
        .i_src_valid (source_valid_i),
        .i_src_sop   (source_sop_i),
        .i_src_eop   (source_eop_i),
        .i_byp_load  (w_byp_load),
        .i_byp_data  (w_byp_data),
        .o_data      (out_data_o),
        .o_valid     (out_valid_o),
        .o_frame_err (frame_err_o)
    );

    assign sink_data_o  = r_sink_data;
    assign sink_valid_o = r_sink_valid;
    assign sink_sop_o   = r_sink_sop;
    assign sink_eop_o   = r_sink_eop;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_fir_tdm_mux.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_mux
// Directed bench for fir_tdm_mux. Instance u_dut1 (NCH=2) has its FIR source
// looped back from its sink through an identity, sign-extending FIR model.
// Instance u_dut2 (NCH=4) has its FIR source driven directly by the bench.
// ---------------------------------------------------------------------------
module tb_fir_tdm_mux;

    logic clk = 1'b0;
    logic rst_n;

    // NCH = 2 instance signals
    logic [31:0] in1;
    logic        iv1, byp1, clr1;
    logic [15:0] sk_d1;
    logic        sk_v1, sk_s1, sk_e1;
    logic [23:0] src_d1;
    logic        src_v1, src_s1, src_e1;
    logic [47:0] out_d1;
    logic        ov1, ovr1, ferr1;

    // NCH = 4 instance signals
    logic [63:0] in2;
    logic        iv2, byp2, clr2;
    logic [15:0] sk_d2;
    logic        sk_v2, sk_s2, sk_e2;
    logic [23:0] src_d2;
    logic        src_v2, src_s2, src_e2;
    logic [95:0] out_d2;
    logic        ov2, ovr2, ferr2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Identity FIR model: sink word sign-extended to 24 bits, same framing.
    assign src_d1 = {{8{sk_d1[15]}}, sk_d1};
    assign src_v1 = sk_v1;
    assign src_s1 = sk_s1;
    assign src_e1 = sk_e1;

    fir_tdm_mux #(.NCH(2), .IN_W(16), .OUT_W(24), .GAP(1)) u_dut1 (
        .AMCLK_i(clk), .nARST(rst_n),
        .in_data_i(in1), .in_valid_i(iv1), .bypass_i(byp1), .clr_i(clr1),
        .sink_data_o(sk_d1), .sink_valid_o(sk_v1), .sink_sop_o(sk_s1), .sink_eop_o(sk_e1),
        .source_data_i(src_d1), .source_valid_i(src_v1), .source_sop_i(src_s1),
        .source_eop_i(src_e1),
        .out_data_o(out_d1), .out_valid_o(ov1), .overrun_o(ovr1), .frame_err_o(ferr1)
    );

    fir_tdm_mux #(.NCH(4), .IN_W(16), .OUT_W(24), .GAP(1)) u_dut2 (
        .AMCLK_i(clk), .nARST(rst_n),
        .in_data_i(in2), .in_valid_i(iv2), .bypass_i(byp2), .clr_i(clr2),
        .sink_data_o(sk_d2), .sink_valid_o(sk_v2), .sink_sop_o(sk_s2), .sink_eop_o(sk_e2),
        .source_data_i(src_d2), .source_valid_i(src_v2), .source_sop_i(src_s2),
        .source_eop_i(src_e2),
        .out_data_o(out_d2), .out_valid_o(ov2), .overrun_o(ovr2), .frame_err_o(ferr2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FIR source word into the NCH=4 instance, held for one cycle.
    task automatic send2(input logic [23:0] d, input logic sop, input logic eop);
        src_d2 = d; src_v2 = 1'b1; src_s2 = sop; src_e2 = eop;
        tick();
        src_v2 = 1'b0; src_s2 = 1'b0; src_e2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in1 = 32'h0; iv1 = 1'b0; byp1 = 1'b0; clr1 = 1'b0;
        in2 = 64'h0; iv2 = 1'b0; byp2 = 1'b0; clr2 = 1'b0;
        src_d2 = 24'h0; src_v2 = 1'b0; src_s2 = 1'b0; src_e2 = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_sink_valid", 128'(sk_v1), 128'h0);
        chk("rst_sink_data", 128'(sk_d1), 128'h0);
        chk("rst_out_data", 128'(out_d1), 128'h0);
        chk("rst_out_valid", 128'(ov1), 128'h0);
        chk("rst_flags", 128'({ovr1, ferr1, ovr2, ferr2}), 128'h0);
        #2 rst_n = 1'b1;
        tick();

        // Normal frame through the identity FIR, then a second 4 cycles later
        in1 = {16'h8001, 16'h1234}; iv1 = 1'b1;
        tick(); iv1 = 1'b0;
        chk("f1_ch0_framing", 128'({sk_v1, sk_s1, sk_e1}), 128'b110);
        chk("f1_ch0_data", 128'(sk_d1), 128'h1234);
        tick();
        chk("f1_ch1_framing", 128'({sk_v1, sk_s1, sk_e1}), 128'b101);
        chk("f1_ch1_data", 128'(sk_d1), 128'h8001);
        chk("f1_no_early_out", 128'(ov1), 128'h0);
        tick();
        chk("f1_gap_idle", 128'(sk_v1), 128'h0);
        chk("f1_out_valid", 128'(ov1), 128'h1);
        chk("f1_out_data", 128'(out_d1), 128'hFF8001_001234);
        tick();
        chk("f1_out_pulse_one", 128'(ov1), 128'h0);
        in1 = {16'h00FF, 16'hFF00}; iv1 = 1'b1;
        tick(); iv1 = 1'b0;
        chk("f2_ch0", 128'({sk_v1, sk_s1, sk_d1}), 128'({2'b11, 16'hFF00}));
        tick(); tick();
        chk("f2_out", 128'({ov1, out_d1}), 128'({1'b1, 48'h0000FF_FFFF00}));
        chk("f2_no_overrun", 128'(ovr1), 128'h0);
        tick();

        // Three back-to-back strobes: A sent, B pending, C dropped
        in1 = {16'h0002, 16'h0001}; iv1 = 1'b1;
        tick();
        in1 = {16'hFFFE, 16'h0003};
        chk("ovr_a_ch0", 128'({sk_s1, sk_d1}), 128'({1'b1, 16'h0001}));
        tick();
        in1 = {16'h5555, 16'h5555};
        tick(); iv1 = 1'b0;
        chk("ovr_set", 128'(ovr1), 128'h1);
        chk("ovr_a_out", 128'({ov1, out_d1}), 128'({1'b1, 48'h000002_000001}));
        tick();
        chk("ovr_b_ch0", 128'({sk_v1, sk_s1, sk_d1}), 128'({2'b11, 16'h0003}));
        tick();
        chk("ovr_b_ch1", 128'({sk_e1, sk_d1}), 128'({1'b1, 16'hFFFE}));
        tick();
        chk("ovr_b_out", 128'({ov1, out_d1}), 128'({1'b1, 48'hFFFFFE_000003}));
        tick(); tick();
        chk("ovr_c_dropped", 128'(sk_v1), 128'h0);
        chk("ovr_sticky", 128'(ovr1), 128'h1);
        clr1 = 1'b1;
        tick(); clr1 = 1'b0;
        chk("ovr_cleared", 128'(ovr1), 128'h0);

        // Bypass: output at t+1, no sink burst
        byp1 = 1'b1; in1 = {16'h8000, 16'h7FFF}; iv1 = 1'b1;
        tick(); iv1 = 1'b0;
        chk("byp_out", 128'({ov1, out_d1}), 128'({1'b1, 48'h800000_7FFF00}));
        chk("byp_no_sink", 128'(sk_v1), 128'h0);
        tick();
        chk("byp_hold", 128'({ov1, sk_v1, out_d1}), 128'({2'b00, 48'h800000_7FFF00}));
        byp1 = 1'b0;

        // NCH=4: early eop is a framing error, next good frame commits
        send2(24'h0000AA, 1'b1, 1'b0);
        send2(24'h0000BB, 1'b0, 1'b0);
        send2(24'h0000CC, 1'b0, 1'b1);
        chk("n4_early_eop_err", 128'(ferr2), 128'h1);
        chk("n4_early_eop_nout", 128'(ov2), 128'h0);
        send2(24'h000011, 1'b1, 1'b0);
        send2(24'h000022, 1'b0, 1'b0);
        send2(24'hABCDEF, 1'b0, 1'b0);
        chk("n4_no_out_before_eop", 128'(ov2), 128'h0);
        send2(24'h800000, 1'b0, 1'b1);
        chk("n4_good_out", 128'({ov2, out_d2}),
            128'({1'b1, 96'h800000_ABCDEF_000022_000011}));
        clr2 = 1'b1;
        tick(); clr2 = 1'b0;
        chk("n4_err_cleared", 128'(ferr2), 128'h0);
        send2(24'h000033, 1'b0, 1'b0);
        chk("n4_no_sop_err", 128'(ferr2), 128'h1);
        clr2 = 1'b1;
        tick(); clr2 = 1'b0;
        send2(24'h000001, 1'b1, 1'b0);
        send2(24'h000002, 1'b0, 1'b0);
        send2(24'h000003, 1'b0, 1'b0);
        send2(24'h000004, 1'b0, 1'b0);
        chk("n4_full_no_eop_ok", 128'({ov2, ferr2}), 128'h0);
        send2(24'h000005, 1'b0, 1'b1);
        chk("n4_past_end_err", 128'({ov2, ferr2}), 128'b01);

        // Reset mid-burst on the NCH=2 instance
        in1 = {16'h7777, 16'h6666}; iv1 = 1'b1;
        tick(); iv1 = 1'b0;
        chk("mrst_burst_started", 128'({sk_v1, sk_s1}), 128'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_sink_clear", 128'({sk_v1, sk_s1, sk_e1, sk_d1}), 128'h0);
        chk("mrst_out_clear", 128'({ov1, out_d1}), 128'h0);
        tick();
        chk("mrst_no_partial", 128'({ov1, sk_v1}), 128'h0);
        #2 rst_n = 1'b1;
        tick();
        in1 = {16'h0004, 16'h0003}; iv1 = 1'b1;
        tick(); iv1 = 1'b0;
        chk("mrst_fresh_sop", 128'({sk_v1, sk_s1, sk_d1}), 128'({2'b11, 16'h0003}));
        tick(); tick();
        chk("mrst_commit", 128'({ov1, out_d1}), 128'({1'b1, 48'h000004_000003}));
        chk("mrst_flags", 128'({ovr1, ferr1}), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
